// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl: tic-tac-toe game controller.
// The human plays X and the computer plays O. Human moves arrive through a
// valid/ready handshake. Computer moves come from an external strategy block
// through a req/valid exchange. The controller validates every move, detects
// wins and draws, and holds the final position until new_game.
// Optional build macro: SCORE_CNT_EN adds saturating win/draw counters.
module ttt_game_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       new_game,
   input  logic       move_valid,
   input  logic [8:0] move,
   output logic       move_ready,
   output logic       strat_req,
   output logic [8:0] strat_ain,
   output logic [8:0] strat_bin,
   input  logic       strat_valid,
   input  logic [8:0] strat_cout,
   output logic [8:0] board_x,
   output logic [8:0] board_o,
   output logic [1:0] status,
   output logic       illegal
`ifdef SCORE_CNT_EN
   ,
   output logic [3:0] x_wins,
   output logic [3:0] o_wins,
   output logic [3:0] draws
`endif
);

   typedef enum logic [2:0] {
      WAIT_H, CHK_H, REQ_C, WAIT_C, CHK_C, DONE
   } state_t;

   localparam logic [1:0] ST_PLAY  = 2'b00;
   localparam logic [1:0] ST_X_WIN = 2'b01;
   localparam logic [1:0] ST_O_WIN = 2'b10;
   localparam logic [1:0] ST_DRAW  = 2'b11;
   localparam logic [8:0] FULL     = 9'h1FF;

   state_t     state_reg, state_next;
   logic [8:0] board_x_reg, board_x_next;
   logic [8:0] board_o_reg, board_o_next;
   logic [8:0] move_reg, move_next;
   logic [8:0] cout_reg, cout_next;
   logic [1:0] status_reg, status_next;
   logic       illegal_reg, illegal_next;

   logic [8:0] occupied;
   logic [8:0] free_sq;
   logic [8:0] lowest_free;
   logic [8:0] x_after;
   logic [8:0] o_pick;
   logic [8:0] o_after;
   logic       human_legal;

   // True when any of the eight lines is fully owned by the board b.
   function automatic logic has_line(input logic [8:0] b);
      return (&b[2:0]) | (&b[5:3]) | (&b[8:6]) |
             (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
             (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
   endfunction

   assign occupied    = board_x_reg | board_o_reg;
   assign free_sq     = ~occupied;
   // Two's-complement trick isolates the lowest set bit of the free mask.
   assign lowest_free = free_sq & (~free_sq + 9'd1);
   assign human_legal = $onehot(move_reg) && ((move_reg & occupied) == 9'd0);
   assign x_after     = board_x_reg | move_reg;
   // A bad strategy proposal (not one-hot, or colliding) falls back to the
   // lowest-index free square, so the computer always makes a legal move.
   assign o_pick      = ($onehot(cout_reg) && ((cout_reg & occupied) == 9'd0))
                        ? cout_reg : lowest_free;
   assign o_after     = board_o_reg | o_pick;

   // Handshake and status outputs are decoded from registers only.
   assign move_ready = (state_reg == WAIT_H);
   assign strat_req  = (state_reg == REQ_C) || (state_reg == WAIT_C);
   assign strat_ain  = board_x_reg;
   assign strat_bin  = board_o_reg;
   assign board_x    = board_x_reg;
   assign board_o    = board_o_reg;
   assign status     = status_reg;
   assign illegal    = illegal_reg;

   // State and datapath registers; reset abandons any game in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= WAIT_H;
         board_x_reg <= '0;
         board_o_reg <= '0;
         move_reg    <= '0;
         cout_reg    <= '0;
         status_reg  <= ST_PLAY;
         illegal_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         board_x_reg <= board_x_next;
         board_o_reg <= board_o_next;
         move_reg    <= move_next;
         cout_reg    <= cout_next;
         status_reg  <= status_next;
         illegal_reg <= illegal_next;
      end
   end

   // Next-state logic; new_game overrides every state and any handshake.
   always_comb begin
      state_next   = state_reg;
      board_x_next = board_x_reg;
      board_o_next = board_o_reg;
      move_next    = move_reg;
      cout_next    = cout_reg;
      status_next  = status_reg;
      illegal_next = 1'b0;
      if (new_game) begin
         state_next   = WAIT_H;
         board_x_next = '0;
         board_o_next = '0;
         move_next    = '0;
         cout_next    = '0;
         status_next  = ST_PLAY;
      end else begin
         case (state_reg)
            WAIT_H: begin
               if (move_valid) begin
                  move_next  = move;
                  state_next = CHK_H;
               end
            end
            CHK_H: begin
               if (human_legal) begin
                  board_x_next = x_after;
                  if (has_line(x_after)) begin
                     status_next = ST_X_WIN;
                     state_next  = DONE;
                  end else if ((x_after | board_o_reg) == FULL) begin
                     status_next = ST_DRAW;
                     state_next  = DONE;
                  end else begin
                     state_next = REQ_C;
                  end
               end else begin
                  illegal_next = 1'b1;
                  state_next   = WAIT_H;
               end
            end
            REQ_C: state_next = WAIT_C;
            WAIT_C: begin
               if (strat_valid) begin
                  cout_next  = strat_cout;
                  state_next = CHK_C;
               end
            end
            CHK_C: begin
               board_o_next = o_after;
               if (has_line(o_after)) begin
                  status_next = ST_O_WIN;
                  state_next  = DONE;
               end else if ((board_x_reg | o_after) == FULL) begin
                  status_next = ST_DRAW;
                  state_next  = DONE;
               end else begin
                  state_next = WAIT_H;
               end
            end
            DONE:    state_next = DONE;
            default: state_next = WAIT_H;
         endcase
      end
   end

`ifdef SCORE_CNT_EN
   logic [3:0] x_wins_reg, o_wins_reg, draws_reg;
   logic       done_entry;

   assign done_entry = (state_next == DONE) && (state_reg != DONE);
   assign x_wins     = x_wins_reg;
   assign o_wins     = o_wins_reg;
   assign draws      = draws_reg;

   // Saturating score counters; only rst_n clears them, not new_game.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_wins_reg <= '0;
         o_wins_reg <= '0;
         draws_reg  <= '0;
      end else if (done_entry) begin
         if (status_next == ST_X_WIN && x_wins_reg != 4'd15) x_wins_reg <= x_wins_reg + 4'd1;
         if (status_next == ST_O_WIN && o_wins_reg != 4'd15) o_wins_reg <= o_wins_reg + 4'd1;
         if (status_next == ST_DRAW  && draws_reg  != 4'd15) draws_reg  <= draws_reg + 4'd1;
      end
   end
`endif

endmodule

// File: doc/ttt_game_ctrl.md
TTT_GAME_CTRL -- requirements
Module: ttt_game_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: new_game  in  1  one-cycle pulse; clears boards and status.
REQ-004 SHALL have ports: move_valid  in  1  human move offered.
REQ-005 SHALL have ports: move  in  9  human square, one-hot (bit0 = top-left, row-major).
REQ-006 SHALL have ports: move_ready  out  1  controller will accept a human move this cycle.
REQ-007 SHALL have ports: strat_req  out  1  request to the move-strategy block.
REQ-008 SHALL have ports: strat_ain  out  9  opponent (human) board given to the strategy block.
REQ-009 SHALL have ports: strat_bin  out  9  own (computer) board given to the strategy block.
REQ-010 SHALL have ports: strat_valid  in  1  strategy result valid.
REQ-011 SHALL have ports: strat_cout  in  9  proposed computer square (one-hot; 0 = no proposal).
REQ-012 SHALL have ports: board_x  out  9  human-occupied squares.
REQ-013 SHALL have ports: board_o  out  9  computer-occupied squares.
REQ-014 SHALL have ports: status  out  2  00 playing, 01 human win, 10 computer win, 11 draw.
REQ-015 SHALL have ports: illegal  out  1  one-cycle pulse on a rejected human move.

Function
REQ-016 SHALL implement states WAIT_H, CHK_H, REQ_C, WAIT_C, CHK_C, DONE.
REQ-017 In WAIT_H: move_ready=1; a handshake (move_valid & move_ready) SHALL register move and go to CHK_H.
REQ-018 Human move legality: exactly one bit set and no overlap with board_x|board_o.
REQ-019 In CHK_H, a legal move SHALL OR into board_x next edge; an illegal move SHALL pulse illegal, leave the boards unchanged, and return to WAIT_H.
REQ-020 After a legal human move, a completed line (3 rows, 3 columns, 2 diagonals) SHALL set status=01 and go to DONE.
REQ-021 Otherwise, a full board (board_x|board_o == 9'h1FF) SHALL set status=11 and go to DONE; otherwise the FSM SHALL go to REQ_C.
REQ-022 In REQ_C and WAIT_C: strat_req=1 and strat_ain/strat_bin SHALL equal board_x/board_o, held stable.
REQ-023 The FSM SHALL leave WAIT_C on the first cycle with strat_valid=1, registering strat_cout.
REQ-024 strat_valid SHALL be ignored outside WAIT_C.
REQ-025 In CHK_C, if strat_cout is not one-hot or hits an occupied square, the controller SHALL substitute the lowest-index free square.
REQ-026 The accepted computer square SHALL OR into board_o.
REQ-027 After the computer move, a completed line SHALL set status=10; otherwise a full board SHALL set status=11; either SHALL go to DONE, otherwise the FSM SHALL return to WAIT_H.
REQ-028 Minimum human-handshake to next move_ready latency SHALL be 4 cycles plus the strategy wait.
REQ-029 In DONE, move_ready=0 and the boards and status SHALL hold until new_game.
REQ-030 new_game SHALL take priority over any state and any simultaneous handshake: next edge boards=0, status=00, state=WAIT_H.
REQ-031 strat_req, move_ready and illegal SHALL be outputs decoded from registered state only, with no combinational path from inputs.

Reset
REQ-032 rst_n low SHALL asynchronously force state=WAIT_H, board_x=board_o=0, status=00, illegal=0, strat_req=0, and all captured moves to 0.
REQ-033 Reset asserted mid-game, including in WAIT_C, SHALL abandon the game; a late strat_valid after release SHALL be ignored.
REQ-034 move_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-035 Macro SCORE_CNT_EN, when defined, SHALL add outputs x_wins[3:0], o_wins[3:0] and draws[3:0], incremented on entry to DONE with the matching status.
REQ-036 The score counters SHALL saturate at 15, clear only on rst_n, and be unaffected by new_game.
REQ-037 Without SCORE_CNT_EN, these ports and their counters SHALL not exist and behaviour SHALL be otherwise identical.

Verification
REQ-038 Reset then an idle cycle -> board_x=board_o=0, status=00, move_ready=1, strat_req=0.
REQ-039 Human 9'b000010000, strategy returns 9'b000000001 -> strat_ain=9'b000010000 and strat_bin=0 during request; board_o=9'b000000001; move_ready returns.
REQ-040 Human plays an occupied square or 9'b000000011 -> illegal pulses once, boards unchanged, strat_req stays 0.
REQ-041 Strategy returns 0 with board_x=9'b000010000, board_o=0 -> board_o=9'b000000001 (fallback).
REQ-042 Human completes top row 9'b000000111 -> status=01, move_ready=0 until new_game, then everything cleared.
REQ-043 Board filled with no line -> status=11; with SCORE_CNT_EN, draws increments 0->1, and x_wins saturates at 15 after 16 human wins.
